// File: rtl/expansion_pkg.sv
// Shared types and helpers for the expansion shift-register plugins.
package expansion_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      BIT_LO = 2'd2,
      BIT_HI = 2'd3
   } state_t;

   // Ticks spent with the load/latch line asserted at the start of a frame.
   localparam int unsigned LOAD_TICKS = 2;

   // Maps the running bit position to the vector index for the chosen bit order.
   function automatic int unsigned bit_index(input int unsigned idx,
                                             input int unsigned width,
                                             input bit          msb_first);
      return msb_first ? (width - 1 - idx) : idx;
   endfunction

endpackage

// File: rtl/expansion_tick.sv
// Clock-enable divider: one-clk tick every SPEED clks while run is high.
module expansion_tick #(
   parameter int unsigned SPEED = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int unsigned   CW     = (SPEED > 1) ? $clog2(SPEED) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(SPEED - 1);

   logic [CW-1:0] cnt;

   // Down-counter held at reload while idle so the first tick is SPEED clks after run rises.
   always_ff @(posedge clk) begin
      if (rst || !run || (cnt == '0)) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

   assign tick = run && (cnt == '0);

endmodule

// File: rtl/expansion_shiftreg_chain.sv
// Frame driver for daisy-chained 74HC595 outputs and 74HC165 inputs on a shared clock/load line.
module expansion_shiftreg_chain
   import expansion_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SPEED       = 100,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter bit          LOAD_ACTIVE = 1'b0,
   parameter bit          CONTINUOUS  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] data_in,
   output logic             SHIFT_OUT,
   input  logic             SHIFT_IN,
   output logic             SHIFT_CLK,
   output logic             SHIFT_LOAD,
   output logic             busy,
   output logic             frame_done
);

   localparam int unsigned    BW        = $clog2(WIDTH) + 1;
   localparam int unsigned    IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned    LCW       = (LOAD_TICKS > 1) ? $clog2(LOAD_TICKS) : 1;
   localparam logic [BW-1:0]  LAST_BIT  = BW'(WIDTH - 1);
   localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_TICKS - 1);
   localparam logic           LOAD_IDLE = ~LOAD_ACTIVE;

   state_t           state;
   logic [WIDTH-1:0] tx;
   logic [WIDTH-1:0] rx;
   logic [BW-1:0]    bit_cnt;
   logic [BW-1:0]    next_bit;
   logic [LCW-1:0]   load_cnt;
   logic [IW-1:0]    out_idx;
   logic [IW-1:0]    in_idx;
   logic             run;
   logic             tick;

   assign run = (state != IDLE);

   expansion_tick #(
      .SPEED (SPEED)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .tick (tick)
   );

   // Index of the bit to present next (first bit when leaving LOAD) and of the bit being sampled.
   always_comb begin
      next_bit = (state == LOAD) ? '0 : (bit_cnt + BW'(1));
      out_idx  = IW'(bit_index(32'(next_bit), WIDTH, MSB_FIRST));
      in_idx   = IW'(bit_index(32'(bit_cnt), WIDTH, MSB_FIRST));
   end

   // Frame sequencer: load/latch phase, then WIDTH low/high shift-clock half periods.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         SHIFT_CLK  <= 1'b0;
         SHIFT_OUT  <= 1'b0;
         SHIFT_LOAD <= LOAD_IDLE;
         data_in    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         tx         <= '0;
         rx         <= '0;
         bit_cnt    <= '0;
         load_cnt   <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (CONTINUOUS || start) begin
                  tx         <= data_out;
                  SHIFT_LOAD <= LOAD_ACTIVE;
                  busy       <= 1'b1;
                  load_cnt   <= '0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (tick) begin
                  if (load_cnt == LOAD_LAST) begin
                     // Releasing the line latches the previous frame into the 595 outputs.
                     SHIFT_LOAD <= LOAD_IDLE;
                     SHIFT_OUT  <= tx[out_idx];
                     bit_cnt    <= '0;
                     state      <= BIT_LO;
                  end else begin
                     load_cnt <= load_cnt + LCW'(1);
                  end
               end
            end
            BIT_LO: begin
               if (tick) begin
                  rx[in_idx] <= SHIFT_IN;
                  SHIFT_CLK  <= 1'b1;
                  state      <= BIT_HI;
               end
            end
            BIT_HI: begin
               if (tick) begin
                  SHIFT_CLK <= 1'b0;
                  if (bit_cnt != LAST_BIT) begin
                     bit_cnt   <= next_bit;
                     SHIFT_OUT <= tx[out_idx];
                     state     <= BIT_LO;
                  end else begin
                     data_in    <= rx;
                     frame_done <= 1'b1;
                     if (CONTINUOUS) begin
                        tx         <= data_out;
                        SHIFT_LOAD <= LOAD_ACTIVE;
                        load_cnt   <= '0;
                        state      <= LOAD;
                     end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_expansion_shiftreg_chain.sv
// Directed bench: two triggered 8-bit chains (MSB/LOAD low, LSB/LOAD high) and one continuous 16-bit chain.
module tb_expansion_shiftreg_chain;

   typedef struct packed {
      logic [7:0] dout;
      logic [7:0] pat;
      logic [7:0] seq_a;
      logic [7:0] seq_b;
      logic       chk_q;
      logic [7:0] q;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_ab, start_ab;
   logic [7:0]  data_out_ab, pat_ab;
   logic [7:0]  data_in_a, data_in_b;
   logic        shift_out_a, shift_in_a, shift_clk_a, shift_load_a, busy_a, frame_done_a;
   logic        shift_out_b, shift_in_b, shift_clk_b, shift_load_b, busy_b, frame_done_b;

   logic        rst_c;
   logic [15:0] data_out_c, pat_c, data_in_c;
   logic        shift_out_c, shift_in_c, shift_clk_c, shift_load_c, busy_c, frame_done_c;

   expansion_shiftreg_chain #(.WIDTH(8), .SPEED(4), .MSB_FIRST(1'b1), .LOAD_ACTIVE(1'b0), .CONTINUOUS(1'b0)) dut_a (
      .clk(clk), .rst(rst_ab), .start(start_ab), .data_out(data_out_ab), .data_in(data_in_a),
      .SHIFT_OUT(shift_out_a), .SHIFT_IN(shift_in_a), .SHIFT_CLK(shift_clk_a), .SHIFT_LOAD(shift_load_a),
      .busy(busy_a), .frame_done(frame_done_a));

   expansion_shiftreg_chain #(.WIDTH(8), .SPEED(4), .MSB_FIRST(1'b0), .LOAD_ACTIVE(1'b1), .CONTINUOUS(1'b0)) dut_b (
      .clk(clk), .rst(rst_ab), .start(start_ab), .data_out(data_out_ab), .data_in(data_in_b),
      .SHIFT_OUT(shift_out_b), .SHIFT_IN(shift_in_b), .SHIFT_CLK(shift_clk_b), .SHIFT_LOAD(shift_load_b),
      .busy(busy_b), .frame_done(frame_done_b));

   expansion_shiftreg_chain #(.WIDTH(16), .SPEED(1), .MSB_FIRST(1'b1), .LOAD_ACTIVE(1'b0), .CONTINUOUS(1'b1)) dut_c (
      .clk(clk), .rst(rst_c), .start(1'b0), .data_out(data_out_c), .data_in(data_in_c),
      .SHIFT_OUT(shift_out_c), .SHIFT_IN(shift_in_c), .SHIFT_CLK(shift_clk_c), .SHIFT_LOAD(shift_load_c),
      .busy(busy_c), .frame_done(frame_done_c));

   // Chain models: 165 loads while the line is asserted, both shift on SHIFT_CLK rise, 595 latches on release.
   logic [7:0]  sr165_a = '0, sr595_a = '0, q595_a = '0, seq_a = '0;
   logic [7:0]  sr165_b = '0, sr595_b = '0, q595_b = '0, seq_b = '0;
   logic [15:0] sr165_c = '0, sr595_c = '0, q595_c = '0, seq_c = '0;
   logic        clk_q_a = 1'b0, ld_q_a = 1'b1, clk_q_b = 1'b0, ld_q_b = 1'b0, clk_q_c = 1'b0, ld_q_c = 1'b1;
   int          rise_a = 0, rise_b = 0;

   assign shift_in_a = sr165_a[7];
   assign shift_in_b = sr165_b[0];
   assign shift_in_c = sr165_c[15];

   // Chain A: MSB first, load active low.
   always @(posedge clk) begin
      clk_q_a <= shift_clk_a;
      ld_q_a  <= shift_load_a;
      if (!shift_load_a) sr165_a <= pat_ab;
      else if (shift_clk_a && !clk_q_a) sr165_a <= {sr165_a[6:0], 1'b0};
      if (shift_clk_a && !clk_q_a) begin
         sr595_a <= {sr595_a[6:0], shift_out_a};
         seq_a   <= {seq_a[6:0], shift_out_a};
         rise_a  <= rise_a + 1;
      end
      if (shift_load_a && !ld_q_a) q595_a <= sr595_a;
   end

   // Chain B: LSB first, load active high.
   always @(posedge clk) begin
      clk_q_b <= shift_clk_b;
      ld_q_b  <= shift_load_b;
      if (shift_load_b) sr165_b <= pat_ab;
      else if (shift_clk_b && !clk_q_b) sr165_b <= {1'b0, sr165_b[7:1]};
      if (shift_clk_b && !clk_q_b) begin
         sr595_b <= {shift_out_b, sr595_b[7:1]};
         seq_b   <= {seq_b[6:0], shift_out_b};
         rise_b  <= rise_b + 1;
      end
      if (!shift_load_b && ld_q_b) q595_b <= sr595_b;
   end

   // Chain C: 16 bits, MSB first, load active low.
   always @(posedge clk) begin
      clk_q_c <= shift_clk_c;
      ld_q_c  <= shift_load_c;
      if (!shift_load_c) sr165_c <= pat_c;
      else if (shift_clk_c && !clk_q_c) sr165_c <= {sr165_c[14:0], 1'b0};
      if (shift_clk_c && !clk_q_c) begin
         sr595_c <= {sr595_c[14:0], shift_out_c};
         seq_c   <= {seq_c[14:0], shift_out_c};
      end
      if (shift_load_c && !ld_q_c) q595_c <= sr595_c;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One triggered frame on chains A and B together.
   task automatic frame_ab(input vec_t v, input string tag);
      int n, ld_b, r0a, r0b;
      bit done;
      @(negedge clk);
      data_out_ab = v.dout;
      pat_ab      = v.pat;
      start_ab    = 1'b1;
      r0a = rise_a;
      r0b = rise_b;
      @(posedge clk); #1;
      start_ab = 1'b0;
      check({tag, "_busy_go"}, 32'(busy_a), 1);
      n = 0; ld_b = 0; done = 1'b0;
      while (n <= 200 && !done) begin
         if (shift_load_b) ld_b++;
         if (frame_done_a) done = 1'b1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      if (!done) begin
         check({tag, "_timeout"}, 0, 1);
      end else begin
         check({tag, "_len"},      32'(n), 72);
         check({tag, "_done_b"},   32'(frame_done_b), 1);
         check({tag, "_din_a"},    32'(data_in_a), 32'(v.pat));
         check({tag, "_din_b"},    32'(data_in_b), 32'(v.pat));
         check({tag, "_busy_a"},   32'(busy_a), 0);
         check({tag, "_busy_b"},   32'(busy_b), 0);
         check({tag, "_seq_a"},    32'(seq_a), 32'(v.seq_a));
         check({tag, "_seq_b"},    32'(seq_b), 32'(v.seq_b));
         check({tag, "_rises_a"},  32'(rise_a - r0a), 8);
         check({tag, "_rises_b"},  32'(rise_b - r0b), 8);
         check({tag, "_ld_hi_b"},  32'(ld_b), 8);
         if (v.chk_q) begin
            check({tag, "_q595_a"}, 32'(q595_a), 32'(v.q));
            check({tag, "_q595_b"}, 32'(q595_b), 32'(v.q));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[4];
      vec_t clean;
      int   n, k, last, dones, first_done;

      vecs[0] = '{dout: 8'hA5, pat: 8'h3C, seq_a: 8'hA5, seq_b: 8'hA5, chk_q: 1'b0, q: 8'h00};
      vecs[1] = '{dout: 8'h01, pat: 8'h81, seq_a: 8'h01, seq_b: 8'h80, chk_q: 1'b1, q: 8'hA5};
      vecs[2] = '{dout: 8'h96, pat: 8'h5A, seq_a: 8'h96, seq_b: 8'h69, chk_q: 1'b1, q: 8'h01};
      vecs[3] = '{dout: 8'hFF, pat: 8'h00, seq_a: 8'hFF, seq_b: 8'hFF, chk_q: 1'b1, q: 8'h96};
      clean   = '{dout: 8'h12, pat: 8'hC5, seq_a: 8'h12, seq_b: 8'h48, chk_q: 1'b0, q: 8'h00};

      rst_ab = 1'b1; rst_c = 1'b1; start_ab = 1'b0;
      data_out_ab = '0; pat_ab = '0; data_out_c = '0; pat_c = 16'hC0DE;
      repeat (3) @(posedge clk);
      #1;
      check("rst_clk_a",  32'(shift_clk_a), 0);
      check("rst_out_a",  32'(shift_out_a), 0);
      check("rst_load_a", 32'(shift_load_a), 1);
      check("rst_load_b", 32'(shift_load_b), 0);
      check("rst_din_a",  32'(data_in_a), 0);
      check("rst_busy_a", 32'(busy_a), 0);
      check("rst_done_a", 32'(frame_done_a), 0);
      check("rst_load_c", 32'(shift_load_c), 1);
      check("rst_busy_c", 32'(busy_c), 0);

      @(negedge clk);
      rst_ab = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("idle_no_start_busy", 32'(busy_a), 0);
      check("idle_no_start_load", 32'(shift_load_a), 1);

      for (int i = 0; i < 4; i++) frame_ab(vecs[i], $sformatf("v%0d", i));

      // Second start while busy must be dropped.
      @(negedge clk);
      data_out_ab = 8'h12; pat_ab = 8'h77; start_ab = 1'b1;
      @(posedge clk); #1;
      start_ab = 1'b0;
      n = 0; dones = 0; first_done = -1;
      while (n < 72 + 150) begin
         if (n == 20) start_ab = 1'b1;
         if (n == 21) start_ab = 1'b0;
         if (frame_done_a) begin
            dones++;
            if (first_done < 0) first_done = n;
         end
         @(posedge clk); #1;
         n++;
      end
      check("busy_start_dones", 32'(dones), 1);
      check("busy_start_len",   32'(first_done), 72);
      check("busy_start_din",   32'(data_in_a), 32'h77);
      check("busy_start_idle",  32'(busy_a), 0);

      // Reset in the middle of bit 5.
      @(negedge clk);
      data_out_ab = 8'hFF; pat_ab = 8'hF0; start_ab = 1'b1;
      @(posedge clk); #1;
      start_ab = 1'b0;
      repeat (50) begin
         @(posedge clk); #1;
      end
      check("mid_busy",  32'(busy_a), 1);
      check("mid_out_a", 32'(shift_out_a), 1);
      rst_ab = 1'b1;
      @(posedge clk); #1;
      check("abort_clk_a",  32'(shift_clk_a), 0);
      check("abort_out_a",  32'(shift_out_a), 0);
      check("abort_out_b",  32'(shift_out_b), 0);
      check("abort_load_a", 32'(shift_load_a), 1);
      check("abort_load_b", 32'(shift_load_b), 0);
      check("abort_busy_a", 32'(busy_a), 0);
      check("abort_busy_b", 32'(busy_b), 0);
      check("abort_din_a",  32'(data_in_a), 0);
      check("abort_din_b",  32'(data_in_b), 0);
      check("abort_done_a", 32'(frame_done_a), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_ab = 1'b0;
      dones = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if (frame_done_a || frame_done_b) dones++;
      end
      check("abort_no_done", 32'(dones), 0);
      check("abort_idle",    32'(busy_a), 0);
      frame_ab(clean, "clean");

      // Continuous chain: data_out changes mid-frame 1.
      @(negedge clk);
      data_out_c = 16'h1234;
      rst_c      = 1'b0;
      @(posedge clk); #1;
      check("c_busy_go", 32'(busy_c), 1);
      check("c_load_go", 32'(shift_load_c), 0);
      n = 0; k = 0; last = 0;
      while (n < 200 && k < 4) begin
         if (n == 50) data_out_c = 16'hBEEF;
         if (frame_done_c) begin
            check($sformatf("c_period%0d", k), 32'(n - last), 34);
            check($sformatf("c_din%0d", k),    32'(data_in_c), 32'hC0DE);
            check($sformatf("c_seq%0d", k),    32'(seq_c), (k < 2) ? 32'h1234 : 32'hBEEF);
            check($sformatf("c_busy%0d", k),   32'(busy_c), 1);
            if (k > 0) check($sformatf("c_q595_%0d", k), 32'(q595_c), (k < 3) ? 32'h1234 : 32'hBEEF);
            last = n;
            k++;
         end
         @(posedge clk); #1;
         n++;
      end
      if (k < 4) check("c_timeout", 32'(k), 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/expansion_shiftreg_chain.md
Name: expansion_shiftreg_chain

Overview:
Parametrised driver for daisy-chained 74HC595 output and 74HC165 input shift registers, sharing one clock line and one load/latch line.
Each frame shifts WIDTH output bits out and WIDTH input bits in. Frame timing comes from a clock-enable tick, not a derived clock, so all logic runs on clk.
It sits between the expansion I/O pins and the RIO register map. It adds over the previous generation:
- reset
- selectable bit order and load polarity
- triggered or continuous mode
- busy and frame_done status
- atomic input update

Parameters:
WIDTH, 8, total chain length in bits (1..256)
SPEED, 100, clk cycles per tick (>=1); one SHIFT_CLK half-period = 1 tick
MSB_FIRST, 1, 1: bit WIDTH-1 shifted first; 0: bit 0 first
LOAD_ACTIVE, 0, asserted level of SHIFT_LOAD
CONTINUOUS, 1, 1: frames run back-to-back; 0: one frame per start pulse

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  frame request, 1-clk pulse (used only when CONTINUOUS=0)
data_out  input  WIDTH  parallel value to drive on 595 outputs
data_in  output  WIDTH  last completed frame of 165 inputs
SHIFT_OUT  output  1  serial data to 595 chain
SHIFT_IN  input  1  serial data from 165 chain
SHIFT_CLK  output  1  shared shift clock
SHIFT_LOAD  output  1  165 parallel-load / 595 storage-latch line
busy  output  1  high while a frame is in progress
frame_done  output  1  1-clk pulse when data_in is updated

Behaviour:
- Reset values (registered outputs, effective the clk after rst is sampled high):
  - SHIFT_CLK=0, SHIFT_OUT=0, SHIFT_LOAD=~LOAD_ACTIVE
  - data_in=0, busy=0, frame_done=0, tick counter=SPEED-1
  - FSM in IDLE
- Reset mid-frame aborts the frame and discards partial input; data_in is cleared, not partially updated.
- Tick generator:
  - Down-counter reloads SPEED-1 on reaching 0; tick = 1-clk pulse at 0.
  - Counter is held at SPEED-1 while in IDLE, so the first tick comes exactly SPEED clks after leaving IDLE.
- FSM states: IDLE, LOAD, BIT_LO, BIT_HI.
- IDLE transitions:
  - CONTINUOUS=1: leave IDLE the clk after reset release.
  - CONTINUOUS=0: leave IDLE on start. start while busy is ignored, not queued.
- IDLE -> LOAD (on the same clk):
  - snapshot data_out into the tx register
  - SHIFT_LOAD=LOAD_ACTIVE, busy=1
- LOAD: lasts 2 ticks, then -> BIT_LO with SHIFT_LOAD inactive. The inactive edge latches the previous frame's data into the 595s, so the outputs lag data_out by one frame.
- BIT_LO (1 tick):
  - Entered with SHIFT_CLK=0 and SHIFT_OUT = current tx bit (MSB_FIRST selects the index order).
  - At its tick: sample SHIFT_IN into rx[bit index] in the same order, set SHIFT_CLK=1, go to BIT_HI.
- BIT_HI (1 tick). At its tick:
  - SHIFT_CLK=0
  - if bits remain: advance index, go to BIT_LO
  - else: data_in<=rx (all WIDTH bits in one clk), frame_done=1 for one clk
- After the last bit:
  - CONTINUOUS=1: LOAD again (re-snapshot data_out).
  - CONTINUOUS=0: IDLE, with busy=0 in the same clk as frame_done.
- Frame length = (2+2*WIDTH)*SPEED clks from leaving IDLE to frame_done.
- The bit counter is $clog2(WIDTH)+1 bits wide; the tick counter is $clog2(SPEED) bits wide (minimum 1). There is no wrap-around beyond WIDTH.
- data_out changes during a frame do not affect the frame in progress.

Decomposition:
- Package expansion_pkg holds:
  - FSM state enum (IDLE, LOAD, BIT_LO, BIT_HI)
  - LOAD_TICKS=2 constant
  - function for the bit index given MSB_FIRST
- Sub-module expansion_tick (parameter SPEED; ports clk, rst, run, tick) holds the clock-enable divider so other expansion plugins can reuse it.

Test Plan:
- WIDTH=8, SPEED=4, CONTINUOUS=0:
  - Set data_out=8'hA5, pulse start; 165 model presents 8'h3C.
  - Required: SHIFT_OUT sequence 1,0,1,0,0,1,0,1 sampled at SHIFT_CLK rising edges.
  - Required: frame_done exactly 72 clks after start; then data_in=8'h3C, busy=0.
- Same setup with MSB_FIRST=0:
  - Required: SHIFT_OUT sequence 1,0,1,0,0,1,0,1 reversed, i.e. LSB first.
  - Required: data_in=8'h3C, given a model that shifts LSB first.
- CONTINUOUS=1, WIDTH=16, SPEED=1:
  - Change data_out mid-frame.
  - Required: the current frame sends the old value; the next frame sends the new value.
  - Required: frame_done period = 34 clks; the 595 model shows each value after the following LOAD.
- Assert rst in the middle of bit 5:
  - Required next clk: all outputs at reset values, data_in=0.
  - Required: no frame_done; after release, a clean frame starts from LOAD.
- CONTINUOUS=0: pulse start again while busy.
  - Required: ignored; exactly one frame_done.
- LOAD_ACTIVE=1:
  - Required: SHIFT_LOAD idles low and is high for exactly 2*SPEED clks per frame.
